// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with valid/ready handshakes, byte-lane stores and extended loads.
// Optional wait states are enabled by defining DMEM_WAIT_STATE_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH_WORDS];

    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic        go;

`ifdef DMEM_WAIT_STATE_EN
    localparam bit          USE_WAIT = (WAIT_CYCLES > 0);
    localparam int unsigned CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] wait_cnt;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [1:0]    lat_size;
    logic          lat_unsigned;

    // Without wait states the access completes on the accepting edge, so it uses the live request.
    always_comb begin
        op_we       = lat_we;
        op_addr     = lat_addr;
        op_wdata    = lat_wdata;
        op_size     = lat_size;
        op_unsigned = lat_unsigned;
        if (state == IDLE) begin
            op_we       = req_we;
            op_addr     = req_addr;
            op_wdata    = req_wdata;
            op_size     = req_size;
            op_unsigned = req_unsigned;
        end
        if (USE_WAIT)
            go = (state == WAIT) && (wait_cnt == '0);
        else
            go = (state == IDLE) && req_valid;
    end
`else
    always_comb begin
        op_we       = req_we;
        op_addr     = req_addr;
        op_wdata    = req_wdata;
        op_size     = req_size;
        op_unsigned = req_unsigned;
        go          = (state == IDLE) && req_valid;
    end
`endif

    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [31:0]   rd_next;
    logic [3:0]    be;
    logic [31:0]   wword;

    always_comb begin
        err = (op_size == 2'd3)
           || ((op_size == 2'd1) && op_addr[0])
           || ((op_size == 2'd2) && (op_addr[1:0] != 2'b00))
           || ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));
        idx     = op_addr[AW+1:2];
        word    = mem[idx];
        shifted = word >> {op_addr[1:0], 3'b000};
        unique case (op_size)
            2'd0:    load_data = op_unsigned ? {24'b0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = op_unsigned ? {16'b0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = word;
        endcase
        rd_next = (err || op_we) ? '0 : load_data;
        unique case (op_size)
            2'd0: begin
                be    = 4'b0001 << op_addr[1:0];
                wword = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                be    = op_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{op_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = op_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (go && op_we && !err && !rst) begin
            for (int unsigned i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
            wait_cnt   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
                        lat_we       <= req_we;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        if (USE_WAIT) begin
                            state    <= WAIT;
                            wait_cnt <= CW'(WAIT_CYCLES - 1);
                        end
`endif
                    end
                end
                WAIT: begin
`ifdef DMEM_WAIT_STATE_EN
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
`endif
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Completion overrides the per-state updates above on the same edge.
            if (go) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_rdata <= rd_next;
                resp_err   <= err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, error cases, back-pressure and reset behaviour.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

`ifdef DMEM_WAIT_STATE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed on the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_rdata"}, resp_rdata, e.rd);
                check({e.name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk);
        #1;
        // Scramble the request lines so only latched values can matter.
        req_valid = 1'b0; req_we = ~we; req_addr = 32'h0000_0004;
        req_wdata = $urandom; req_size = 2'd2; req_unsigned = ~uns;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        int n;
        exp_q.push_back('{exp_rd, exp_err, name});
        issue(we, addr, wdata, size, uns);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 50);
        check({name, "_latency"}, n, LAT);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_resp_err", {31'b0, resp_err}, 32'd0);

        access(1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0, "sw_10");
        access(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0, "lw_10");
        access(0, 32'h13, 32'h0, 2'd0, 0, 32'hFFFFFFDE, 0, "lb_13");
        access(0, 32'h13, 32'h0, 2'd0, 1, 32'h000000DE, 0, "lbu_13");
        access(0, 32'h10, 32'h0, 2'd1, 0, 32'hFFFFBEEF, 0, "lh_10");
        access(0, 32'h12, 32'h0, 2'd1, 1, 32'h0000DEAD, 0, "lhu_12");
        access(0, 32'h10, 32'h0, 2'd0, 0, 32'hFFFFFFEF, 0, "lb_10");
        access(1, 32'h11, 32'h55, 2'd0, 0, 32'h0, 0, "sb_11");
        access(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEAD55EF, 0, "lw_10_after_sb");

        access(1, 32'h20, 32'h12345678, 2'd2, 0, 32'h0, 0, "sw_20");
        access(0, 32'h12, 32'h0, 2'd2, 0, 32'h0, 1, "lw_misaligned");
        access(1, 32'h21, 32'hFFFF, 2'd1, 0, 32'h0, 1, "sh_misaligned");
        access(1, 32'h20, 32'hFFFFFFFF, 2'd3, 0, 32'h0, 1, "size3_store");
        access(1, 32'h1000, 32'hFFFFFFFF, 2'd2, 0, 32'h0, 1, "sw_out_of_range");
        access(0, 32'h20, 32'h0, 2'd2, 0, 32'h12345678, 0, "lw_20_unchanged");
        access(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEAD55EF, 0, "lw_10_unchanged");
        access(1, 32'h22, 32'hABCD, 2'd1, 0, 32'h0, 0, "sh_22");
        access(0, 32'h20, 32'h0, 2'd2, 0, 32'hABCD5678, 0, "lw_20_after_sh");
        access(1, 32'hFFC, 32'h0BADF00D, 2'd2, 0, 32'h0, 0, "sw_last");
        access(0, 32'hFFE, 32'h0, 2'd1, 0, 32'h00000BAD, 0, "lh_last");
        drain();

        // Back-pressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        access(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEAD55EF, 0, "lw_stall");
        for (int i = 0; i < 5; i++) begin
            check("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_resp_rdata", resp_rdata, 32'hDEAD55EF);
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'h0;
        check("consume_cycle_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("after_consume_req_ready", {31'b0, req_ready}, 32'd1);
        check("after_consume_resp_valid", {31'b0, resp_valid}, 32'd0);
        drain();

        // Storage survives reset.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        access(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEAD55EF, 0, "lw_after_reset");
        drain();

`ifdef DMEM_WAIT_STATE_EN
        access(1, 32'h30, 32'h11111111, 2'd2, 0, 32'h0, 0, "sw_30");
        drain();
        issue(1, 32'h30, 32'h22222222, 2'd2, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        access(0, 32'h30, 32'h0, 2'd2, 0, 32'h11111111, 0, "lw_30_after_abort");
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait states per access when DMEM_WAIT_STATE_EN is defined.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
  clk  input  1  clock, rising edge
  rst  input  1  reset, synchronous, active-high
  req_valid  input  1  request offered by the memory stage
  req_ready  output  1  responder can accept a request
  req_we  input  1  1=store, 0=load
  req_addr  input  32  byte address
  req_wdata  input  32  store data, right-aligned
  req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
  req_unsigned  input  1  zero-extend loads (LBU/LHU)
  resp_valid  output  1  response available
  resp_ready  input  1  memory stage accepts response
  resp_rdata  output  32  load result, extended
  resp_err  output  1  misaligned, illegal size or out-of-range access

Function
REQ-004 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-005 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clk edge with req_valid&&req_ready.
REQ-006 SHALL latch we, addr, wdata, size and unsigned on acceptance; later changes to req_* SHALL NOT affect the access.
REQ-007 SHALL flag error when size=3, half addr[0]!=0, word addr[1:0]!=0, or addr[31:2]>=DEPTH_WORDS.
REQ-008 SHALL, on an erroring access, perform no write and return resp_rdata=0, resp_err=1.
REQ-009 SHALL, on a store, update only the addressed byte lanes (byte: 1 lane, half: 2, word: 4) on the edge entering RESP; resp_rdata=0.
REQ-010 SHALL, on a load, select the addressed byte/half/word and sign-extend, or zero-extend when unsigned=1.
REQ-011 SHALL return load data reflecting every store whose response has already been issued (read-after-write coherent).
REQ-012 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-013 SHALL NOT accept a new request in the cycle a response is consumed (req_ready rises the next cycle).
REQ-014 SHALL, with zero wait states, go IDLE->RESP on acceptance: resp_valid high in the cycle after acceptance.
REQ-015 SHALL, in WAIT, decrement a wait counter loaded with WAIT_CYCLES-1 and go to RESP when it reaches 0.
REQ-016 SHALL ignore resp_ready outside RESP and req_valid outside IDLE.

Reset
REQ-017 SHALL, on rst, force state=IDLE, req_ready=1 (from the first cycle after reset), resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
REQ-018 SHALL, on rst mid-access (WAIT), abort the access with no write and no response.
REQ-019 SHALL NOT clear storage contents on reset.

Configuration
REQ-020 SHALL, when DMEM_WAIT_STATE_EN is defined and WAIT_CYCLES>0, pass through WAIT for exactly WAIT_CYCLES cycles: resp_valid first high WAIT_CYCLES+1 cycles after acceptance.
REQ-021 SHALL, when DMEM_WAIT_STATE_EN is undefined or WAIT_CYCLES=0, omit WAIT and its counter and use the REQ-014 latency.

Verification
REQ-022 SHALL pass: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
REQ-023 SHALL pass: after REQ-022, load byte @0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half @0x10 signed -> 0xFFFFBEEF.
REQ-024 SHALL pass: store byte 0x55 @0x11 over 0xDEADBEEF, then load word @0x10 -> 0xDEAD55EF.
REQ-025 SHALL pass: load word @0x12 or store half @0x21 -> resp_err=1, resp_rdata=0, memory unchanged.
REQ-026 SHALL pass: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
REQ-027 SHALL pass: with DMEM_WAIT_STATE_EN and WAIT_CYCLES=2, load accepted at cycle N -> resp_valid first high at N+3; rst asserted at N+1 during a store -> no write, resp_valid stays 0.
